// File: rtl/eth_rx_stream_packer.sv
// eth_rx_stream_packer
//
// Packs the MAC receive byte stream (little-endian) into 32-bit AXI4-Stream
// words with TKEEP, TLAST and a frame-error flag on TUSER. Packed words go
// through a small first-word-fall-through FIFO so the non-stallable byte
// stream can ride out DMA backpressure. When the FIFO cannot take a word,
// the rest of the frame is discarded. A frame that already emitted words is
// closed with an empty TLAST/TUSER terminator beat. A frame that emitted
// nothing is dropped silently.
//
// Optional feature macro: ETH_RX_DROP_CNT_EN builds the saturating
// overflowed-frame counter on rx_drop_cnt. When the macro is undefined, the
// port is tied to zero.
//
// Ports
//   Aclk, Areset     clock, asynchronous active-high reset
//   rx_byte*         MAC receive byte, valid, last-of-frame and error
//                    (error is qualified by last)
//   TVALID/TREADY    AXI4-Stream handshake
//   TDATA/TKEEP      packed word and byte qualifiers; first byte in [7:0]
//   TLAST/TUSER      end of frame; TUSER=1 on TLAST marks a bad or
//                    truncated frame
//   rx_overflow      one-cycle pulse when a frame starts discarding
//   rx_drop_cnt      number of overflowed frames
module eth_rx_stream_packer #(
  parameter int data_width = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  Aclk,
  input  logic                  Areset,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_byte_valid,
  input  logic                  rx_byte_last,
  input  logic                  rx_byte_err,
  output logic                  TVALID,
  input  logic                  TREADY,
  output logic [data_width-1:0] TDATA,
  output logic [3:0]            TKEEP,
  output logic                  TLAST,
  output logic                  TUSER,
  output logic                  rx_overflow,
  output logic [15:0]           rx_drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = data_width + 6;  // {user, last, keep[3:0], data}
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(FIFO_DEPTH - 1);
  localparam logic [EW-1:0] TERM_WORD = {1'b1, 1'b1, 4'b0000, {data_width{1'b0}}};

  typedef enum logic [1:0] {SYNC, PACK, DISCARD} state_t;

  state_t                state_q;
  logic [1:0]            idx_q;
  logic [data_width-1:0] stage_q;
  logic                  started_q;
  logic                  wr_vld_q;
  logic [EW-1:0]         wr_word_q;
  logic                  ovf_q;

  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [EW-1:0]         mem [FIFO_DEPTH];

  logic [data_width-1:0] word_now;
  logic [3:0]            keep_now;
  logic                  due;
  logic                  room;
  logic [CW-1:0]         occ;
  logic                  push, pop;
  logic [EW-1:0]         head;

  // Staging word plus the incoming byte at its lane. Unused lanes stay zero
  // because the staging word is cleared whenever a word is due.
  always_comb begin
    word_now = stage_q | (data_width'(rx_byte) << {idx_q, 3'b000});
    case (idx_q)
      2'd0:    keep_now = 4'b0001;
      2'd1:    keep_now = 4'b0011;
      2'd2:    keep_now = 4'b0111;
      default: keep_now = 4'b1111;
    endcase
  end

  assign due = rx_byte_valid && ((idx_q == 2'd3) || rx_byte_last);

  // The word in the write register lands at the next edge, so it is counted
  // as occupied. Otherwise back-to-back due words could consume the slot
  // reserved for the terminator.
  assign occ  = count_q + (wr_vld_q ? CNT_ONE : '0);
  assign room = occ < CNT_LIMIT;

  // Packer FSM. Due words are registered here and written to the FIFO one
  // edge later.
  always_ff @(posedge Aclk or posedge Areset) begin
    if (Areset) begin
      state_q   <= SYNC;
      idx_q     <= 2'd0;
      stage_q   <= '0;
      started_q <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_word_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
      unique case (state_q)
        SYNC: begin
          // Joining mid-frame would emit a truncated frame; wait for a boundary.
          if (rx_byte_valid && rx_byte_last) state_q <= PACK;
        end
        PACK: begin
          if (rx_byte_valid) begin
            if (!due) begin
              idx_q   <= idx_q + 2'd1;
              stage_q <= word_now;
            end else begin
              idx_q   <= 2'd0;
              stage_q <= '0;
              if (room) begin
                wr_vld_q  <= 1'b1;
                wr_word_q <= {rx_byte_last & rx_byte_err, rx_byte_last, keep_now, word_now};
                started_q <= !rx_byte_last;
              end else begin
                ovf_q <= 1'b1;
                if (rx_byte_last) begin
                  // Overflow on the final byte: close the frame right away.
                  if (started_q) begin
                    wr_vld_q  <= 1'b1;
                    wr_word_q <= TERM_WORD;
                  end
                  started_q <= 1'b0;
                  state_q   <= PACK;
                end else begin
                  state_q <= DISCARD;
                end
              end
            end
          end
        end
        DISCARD: begin
          if (rx_byte_valid && rx_byte_last) begin
            // The reserved FIFO slot guarantees this write fits.
            if (started_q) begin
              wr_vld_q  <= 1'b1;
              wr_word_q <= TERM_WORD;
            end
            started_q <= 1'b0;
            state_q   <= PACK;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign rx_overflow = ovf_q;

`ifdef ETH_RX_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic        enter_discard;

  assign enter_discard = (state_q == PACK) && due && !room;

  always_ff @(posedge Aclk or posedge Areset) begin
    if (Areset) begin
      drop_cnt_q <= 16'd0;
    end else if (enter_discard && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign rx_drop_cnt = drop_cnt_q;
`else
  assign rx_drop_cnt = 16'd0;
`endif

  // FWFT word FIFO
  assign push = wr_vld_q;
  assign pop  = TVALID && TREADY;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Aclk or posedge Areset) begin
    if (Areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge Aclk) begin
    if (push) mem[wr_ptr_q] <= wr_word_q;
  end

  // Outputs are masked while empty, so they show zeros out of reset and
  // never expose stale storage.
  assign head   = mem[rd_ptr_q];
  assign TVALID = (count_q != '0);
  assign TDATA  = TVALID ? head[data_width-1:0]           : '0;
  assign TKEEP  = TVALID ? head[data_width+3:data_width]  : 4'b0000;
  assign TLAST  = TVALID ? head[data_width+4]             : 1'b0;
  assign TUSER  = TVALID ? head[data_width+5]             : 1'b0;

endmodule

// File: tb/tb_eth_rx_stream_packer.sv
module tb_eth_rx_stream_packer;

`ifdef ETH_RX_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        Aclk = 1'b0;
  logic        Areset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_byte_valid = 1'b0;
  logic        rx_byte_last = 1'b0;
  logic        rx_byte_err = 1'b0;
  logic        TREADY = 1'b0;
  logic        TVALID;
  logic [31:0] TDATA;
  logic [3:0]  TKEEP;
  logic        TLAST;
  logic        TUSER;
  logic        rx_overflow;
  logic [15:0] rx_drop_cnt;

  eth_rx_stream_packer #(.data_width(32), .FIFO_DEPTH(8)) dut (
    .Aclk(Aclk), .Areset(Areset),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .rx_byte_last(rx_byte_last), .rx_byte_err(rx_byte_err),
    .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA), .TKEEP(TKEEP),
    .TLAST(TLAST), .TUSER(TUSER),
    .rx_overflow(rx_overflow), .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 Aclk = ~Aclk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    beats = 0;
  int    ovf_pulses = 0;
  int    exp_drops = 0;
  bit    stall_q = 1'b0;
  beat_t hold;
  bit    bp_done = 1'b0;

  // Scoreboard monitor: sampled on the falling edge, between driving edges.
  always @(negedge Aclk) begin
    if (Areset) begin
      stall_q = 1'b0;
    end else begin
      if (rx_overflow) ovf_pulses++;
      if (stall_q) begin
        checks++;
        if (TVALID !== 1'b1 || {TDATA, TKEEP, TLAST, TUSER} !== hold) begin
          failures++;
          $display("FAIL stall_stable: got v=%b %h/%b/%b/%b required v=1 %h/%b/%b/%b",
                   TVALID, TDATA, TKEEP, TLAST, TUSER, hold.d, hold.k, hold.l, hold.u);
        end
      end
      if (TVALID === 1'b1 && TREADY === 1'b1) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got %h/%b/%b/%b required no beat",
                   TDATA, TKEEP, TLAST, TUSER);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if ({TDATA, TKEEP, TLAST, TUSER} !== e) begin
            failures++;
            $display("FAIL beat: got %h/%b/%b/%b required %h/%b/%b/%b",
                     TDATA, TKEEP, TLAST, TUSER, e.d, e.k, e.l, e.u);
          end
        end
      end
      stall_q = (TVALID === 1'b1) && (TREADY !== 1'b1);
      hold    = {TDATA, TKEEP, TLAST, TUSER};
    end
  end

  task automatic put_byte(input logic [7:0] b, input logic last, input logic err);
    @(posedge Aclk); #1;
    rx_byte = b; rx_byte_valid = 1'b1; rx_byte_last = last; rx_byte_err = err & last;
  endtask

  task automatic idle();
    @(posedge Aclk); #1;
    rx_byte = 8'h00; rx_byte_valid = 1'b0; rx_byte_last = 1'b0; rx_byte_err = 1'b0;
  endtask

  // Sends bytes base, base+1, ... and optionally queues the beats a
  // reference packer would produce for them.
  task automatic send_frame(input int n, input logic [7:0] base, input logic err, input bit expect_out);
    logic [31:0] w;
    logic [3:0]  k;
    logic [7:0]  b;
    int          lane;
    w = '0; k = '0; lane = 0;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      put_byte(b, (i == n - 1), err);
      w[lane*8 +: 8] = b;
      k[lane] = 1'b1;
      lane++;
      if (lane == 4 || i == n - 1) begin
        if (expect_out) exp_q.push_back({w, k, (i == n - 1), (i == n - 1) && err});
        w = '0; k = '0; lane = 0;
      end
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || TVALID === 1'b1) && c < budget) begin
      @(negedge Aclk); c++;
    end
    @(negedge Aclk);
    checks++;
    if (exp_q.size() != 0 || TVALID !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: got pending=%0d TVALID=%b required pending=0 TVALID=0",
               name, exp_q.size(), TVALID);
    end
  endtask

  task automatic check_reset_values(input string name);
    logic [31:0] act [7];
    string       nm  [7];
    act[0] = 32'(TVALID); nm[0] = "TVALID";
    act[1] = 32'(TLAST);  nm[1] = "TLAST";
    act[2] = 32'(TUSER);  nm[2] = "TUSER";
    act[3] = 32'(rx_overflow); nm[3] = "rx_overflow";
    act[4] = TDATA;       nm[4] = "TDATA";
    act[5] = 32'(TKEEP);  nm[5] = "TKEEP";
    act[6] = 32'(rx_drop_cnt); nm[6] = "rx_drop_cnt";
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (act[i] !== 32'd0) begin
        failures++;
        $display("FAIL %s_%s: got %h required 0", name, nm[i], act[i]);
      end
    end
  endtask

  task automatic check_drops(input string name);
    logic [15:0] want;
    want = CNT_EN ? 16'(exp_drops) : 16'd0;
    checks++;
    if (rx_drop_cnt !== want) begin
      failures++;
      $display("FAIL %s_drop_cnt: got %0d required %0d", name, rx_drop_cnt, want);
    end
  endtask

  task automatic test_reset();
    Areset = 1'b1;
    repeat (3) @(negedge Aclk);
    check_reset_values("reset");
    @(posedge Aclk); #1;
    Areset = 1'b0;
    repeat (2) @(posedge Aclk);
  endtask

  task automatic test_basic();
    TREADY = 1'b1;
    send_frame(1, 8'hEE, 1'b0, 1'b0);  // leaves SYNC, no output
    idle();
    exp_q.push_back({32'h04030201, 4'b1111, 1'b0, 1'b0});
    exp_q.push_back({32'h00000605, 4'b0011, 1'b1, 1'b0});
    send_frame(6, 8'h01, 1'b0, 1'b0);
    idle();
    wait_drain(50, "basic");
  endtask

  task automatic test_latency();
    TREADY = 1'b0;
    exp_q.push_back({32'h0000005A, 4'b0001, 1'b1, 1'b0});
    put_byte(8'h5A, 1'b1, 1'b0);
    idle();  // byte sampled at this edge
    @(negedge Aclk);
    checks++;
    if (TVALID !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: got TVALID=%b required 0", TVALID);
    end
    @(negedge Aclk);
    checks++;
    if (TVALID !== 1'b1) begin
      failures++;
      $display("FAIL latency_valid: got TVALID=%b required 1", TVALID);
    end
    @(posedge Aclk); #1;
    TREADY = 1'b1;
    wait_drain(20, "latency");
  endtask

  task automatic test_error_single();
    TREADY = 1'b1;
    send_frame(4, 8'h30, 1'b1, 1'b1);
    idle();
    send_frame(1, 8'hAA, 1'b0, 1'b1);
    idle();
    wait_drain(50, "err_single");
  endtask

  task automatic test_back_to_back();
    TREADY = 1'b1;
    send_frame(1, 8'h11, 1'b0, 1'b1);
    send_frame(2, 8'h21, 1'b1, 1'b1);
    send_frame(5, 8'h31, 1'b0, 1'b1);
    send_frame(1, 8'h41, 1'b0, 1'b1);
    idle();
    wait_drain(60, "b2b");
  endtask

  task automatic test_overflow();
    int ovf0, beats0;
    logic [31:0] w;
    TREADY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'h40 + 8'(4 * i + j);
      exp_q.push_back({w, 4'b1111, 1'b0, 1'b0});
    end
    exp_q.push_back({32'h0, 4'b0000, 1'b1, 1'b1});
    ovf0 = ovf_pulses;
    send_frame(40, 8'h40, 1'b0, 1'b0);
    idle();
    repeat (3) @(negedge Aclk);
    exp_drops++;
    checks++;
    if (ovf_pulses - ovf0 != 1) begin
      failures++;
      $display("FAIL overflow_pulse: got %0d pulses required 1", ovf_pulses - ovf0);
    end
    check_drops("overflow");
    beats0 = beats;
    @(posedge Aclk); #1;
    TREADY = 1'b1;
    wait_drain(60, "overflow");
    checks++;
    if (beats - beats0 != 8) begin
      failures++;
      $display("FAIL overflow_beats: got %0d required 8", beats - beats0);
    end
  endtask

  task automatic test_silent_drop();
    int ovf0, beats0;
    TREADY = 1'b0;
    send_frame(28, 8'h80, 1'b0, 1'b1);  // fills 7 entries
    idle();
    ovf0 = ovf_pulses;
    send_frame(8, 8'hC0, 1'b0, 1'b0);
    idle();
    repeat (3) @(negedge Aclk);
    exp_drops++;
    checks++;
    if (ovf_pulses - ovf0 != 1) begin
      failures++;
      $display("FAIL silent_pulse: got %0d pulses required 1", ovf_pulses - ovf0);
    end
    check_drops("silent");
    beats0 = beats;
    @(posedge Aclk); #1;
    TREADY = 1'b1;
    wait_drain(60, "silent");
    checks++;
    if (beats - beats0 != 7) begin
      failures++;
      $display("FAIL silent_beats: got %0d required 7", beats - beats0);
    end
    send_frame(5, 8'hD0, 1'b0, 1'b1);
    idle();
    wait_drain(40, "silent_next");
  endtask

  task automatic test_backpressure();
    int ovf0, beats0;
    ovf0 = ovf_pulses;
    beats0 = beats;
    bp_done = 1'b0;
    fork
      begin
        send_frame(64, 8'h00, 1'b0, 1'b1);
        idle();
        bp_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(bp_done && exp_q.size() == 0) && cyc < 600) begin
          @(posedge Aclk); #1;
          TREADY = (cyc % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
          cyc++;
        end
        TREADY = 1'b1;
      end
    join
    wait_drain(40, "backpressure");
    checks++;
    if (beats - beats0 != 16 || ovf_pulses != ovf0) begin
      failures++;
      $display("FAIL backpressure_count: got beats=%0d ovf=%0d required beats=16 ovf=0",
               beats - beats0, ovf_pulses - ovf0);
    end
  endtask

  task automatic test_reset_midframe();
    int beats0;
    TREADY = 1'b1;
    put_byte(8'h60, 1'b0, 1'b0);
    put_byte(8'h61, 1'b0, 1'b0);
    put_byte(8'h62, 1'b0, 1'b0);
    @(posedge Aclk); #1;
    Areset = 1'b1;
    rx_byte_valid = 1'b0;
    #2;
    exp_drops = 0;
    check_reset_values("midreset");
    @(posedge Aclk); #1;
    Areset = 1'b0;
    beats0 = beats;
    send_frame(5, 8'h70, 1'b0, 1'b0);  // tail of the interrupted frame
    idle();
    send_frame(4, 8'h90, 1'b0, 1'b1);
    idle();
    wait_drain(40, "midreset");
    checks++;
    if (beats - beats0 != 1) begin
      failures++;
      $display("FAIL midreset_beats: got %0d required 1", beats - beats0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_error_single();
    test_back_to_back();
    test_overflow();
    test_silent_drop();
    test_backpressure();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
